branch_target_predictor: RTL and testbench

//   Parametrised branch target buffer (BTB) with 2-bit saturating direction counters for the 5-stage pipe.

---
 rtl/branch_target_predictor.sv | 146 ++++++++++++++
 tb/tb_branch_target_predictor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters for the IF stage.
// Lookup is combinational on the fetch PC; training arrives from MEM; saturating bring-up statistics.
module branch_target_predictor #(
    parameter int ENTRIES   = 16,
    parameter int ADDR_W    = 32,
    parameter int TAG_W     = 8,
    parameter int ALLOC_CTR = 2,
    parameter int STAT_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic              flush_all,
    input  logic              stat_clear,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);
    localparam int IDX_W = $clog2(ENTRIES);

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        sat_inc = (c == 2'd3) ? 2'd3 : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        sat_dec = (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] s);
        stat_inc = (s == {STAT_W{1'b1}}) ? s : s + {{(STAT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [ADDR_W-1:0]  target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [STAT_W-1:0]  branches_q, branches_d;
    logic [STAT_W-1:0]  mispred_q, mispred_d;

    logic [IDX_W-1:0] if_idx_s, upd_idx_s;
    logic [TAG_W-1:0] if_tag_s, upd_tag_s;
    logic             upd_hit_s;

    assign if_idx_s  = if_pc[IDX_W+1:2];
    assign if_tag_s  = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_idx_s = upd_pc[IDX_W+1:2];
    assign upd_tag_s = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_hit_s = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);

    // Fetch-side lookup: reads pre-update contents, no bypass from a same-cycle update.
    always_comb begin
        pred_hit    = valid_q[if_idx_s] && (tag_q[if_idx_s] == if_tag_s);
        pred_taken  = pred_hit && ctr_q[if_idx_s][1];
        pred_target = if_pc + ADDR_W'(4);
        if (pred_taken) begin
            pred_target = target_q[if_idx_s];
        end else begin
            pred_target = if_pc + ADDR_W'(4);
        end
    end

    // Table training; a flush drops every entry and suppresses the simultaneous update.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (flush_all) begin
            valid_d = '0;
        end else if (upd_valid) begin
            case ({upd_hit_s, upd_taken})
                2'b11: begin
                    ctr_d[upd_idx_s]    = sat_inc(ctr_q[upd_idx_s]);
                    target_d[upd_idx_s] = upd_target;
                end
                2'b10: begin
                    ctr_d[upd_idx_s] = sat_dec(ctr_q[upd_idx_s]);
                end
                2'b01: begin
                    valid_d[upd_idx_s]  = 1'b1;
                    tag_d[upd_idx_s]    = upd_tag_s;
                    target_d[upd_idx_s] = upd_target;
                    ctr_d[upd_idx_s]    = 2'(ALLOC_CTR);
                end
                default: begin
                    valid_d = valid_q;
                end
            endcase
        end else begin
            valid_d = valid_q;
        end
    end

    // Statistics: clear beats increment; flushed updates are still counted.
    always_comb begin
        branches_d = branches_q;
        mispred_d  = mispred_q;
        if (stat_clear) begin
            branches_d = '0;
            mispred_d  = '0;
        end else if (upd_valid) begin
            branches_d = stat_inc(branches_q);
            if (upd_pred_taken != upd_taken) begin
                mispred_d = stat_inc(mispred_q);
            end else begin
                mispred_d = mispred_q;
            end
        end else begin
            branches_d = branches_q;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q    <= '0;
            branches_q <= '0;
            mispred_q  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'd0;
            end
        end else begin
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            target_q   <= target_d;
            ctr_q      <= ctr_d;
            branches_q <= branches_d;
            mispred_q  <= mispred_d;
        end
    end

    assign stat_branches = branches_q;
    assign stat_mispred  = mispred_q;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: lookup, training, aliasing, flush, stats, reset, saturation.
module tb_branch_target_predictor;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid, upd_taken, upd_pred_taken;
    logic [31:0] upd_pc, upd_target;
    logic        flush_all, stat_clear;
    logic [15:0] stat_branches, stat_mispred;

    logic        s_upd_valid;
    logic        s_hit, s_taken;
    logic [31:0] s_target;
    logic [3:0]  s_branches, s_mispred;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    branch_target_predictor dut (
        .clock(clock), .reset(reset), .if_pc(if_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .flush_all(flush_all), .stat_clear(stat_clear),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    branch_target_predictor #(.STAT_W(4)) dut_sat (
        .clock(clock), .reset(reset), .if_pc(if_pc),
        .pred_hit(s_hit), .pred_taken(s_taken), .pred_target(s_target),
        .upd_valid(s_upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .flush_all(flush_all), .stat_clear(stat_clear),
        .stat_branches(s_branches), .stat_mispred(s_mispred)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic look(input logic [31:0] pc);
        if_pc = pc;
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic ptk);
        upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_pred_taken = ptk;
        upd_valid = 1'b1;
        step();
        upd_valid = 1'b0;
    endtask

    task automatic expect_pred(input string tag, input logic h, input logic t, input logic [31:0] tgt);
        check({tag, "_hit"}, 32'(pred_hit), 32'(h));
        check({tag, "_taken"}, 32'(pred_taken), 32'(t));
        check({tag, "_target"}, pred_target, tgt);
    endtask

    task automatic expect_stats(input string tag, input logic [15:0] b, input logic [15:0] m);
        check({tag, "_branches"}, 32'(stat_branches), 32'(b));
        check({tag, "_mispred"}, 32'(stat_mispred), 32'(m));
    endtask

    initial begin
        reset = 1'b1; if_pc = 32'h40;
        upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0; upd_target = 32'h0;
        upd_pred_taken = 1'b0; flush_all = 1'b0; stat_clear = 1'b0; s_upd_valid = 1'b0;
        #3;
        expect_pred("reset", 1'b0, 1'b0, 32'h44);
        expect_stats("reset", 16'd0, 16'd0);
        step();
        reset = 1'b0;

        // Allocation; lookup in the same cycle still sees the old (empty) entry.
        upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h80; upd_pred_taken = 1'b0;
        upd_valid = 1'b1;
        #1;
        expect_pred("no_bypass", 1'b0, 1'b0, 32'h44);
        step();
        upd_valid = 1'b0;
        #1;
        expect_pred("alloc", 1'b1, 1'b1, 32'h80);
        expect_stats("alloc", 16'd1, 16'd1);

        // Counter: 2 -> 3 -> 3 -> 2 -> 1 -> 0, then +1 shows 0 held rather than wrapping.
        upd(32'h40, 1'b1, 32'h80, 1'b1);
        upd(32'h40, 1'b1, 32'h80, 1'b1);
        upd(32'h40, 1'b0, 32'h0, 1'b1);
        expect_pred("ctr2", 1'b1, 1'b1, 32'h80);
        upd(32'h40, 1'b0, 32'h0, 1'b1);
        expect_pred("ctr1", 1'b1, 1'b0, 32'h44);
        expect_stats("ctr1", 16'd5, 16'd3);
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        upd(32'h40, 1'b1, 32'h80, 1'b0);
        expect_pred("ctr_floor", 1'b1, 1'b0, 32'h44);
        expect_stats("ctr_floor", 16'd8, 16'd4);

        // Alias replaces index 0; a not-taken miss allocates nothing.
        upd(32'h440, 1'b1, 32'h100, 1'b0);
        look(32'h440);
        expect_pred("alias", 1'b1, 1'b1, 32'h100);
        look(32'h40);
        expect_pred("alias_old", 1'b0, 1'b0, 32'h44);
        upd(32'h20, 1'b0, 32'h0, 1'b0);
        look(32'h20);
        expect_pred("nt_miss", 1'b0, 1'b0, 32'h24);
        // Target-only change: table updates, mispredict not counted.
        upd(32'h440, 1'b1, 32'h200, 1'b1);
        look(32'h440);
        expect_pred("retarget", 1'b1, 1'b1, 32'h200);
        expect_stats("retarget", 16'd11, 16'd5);
        look(32'hFFFF_FFFC);
        expect_pred("wrap", 1'b0, 1'b0, 32'h0);

        // Flush beats a simultaneous allocation but the update is still counted.
        flush_all = 1'b1;
        upd(32'h40, 1'b1, 32'h80, 1'b0);
        flush_all = 1'b0;
        look(32'h440);
        expect_pred("flush_alias", 1'b0, 1'b0, 32'h444);
        look(32'h40);
        expect_pred("flush_noalloc", 1'b0, 1'b0, 32'h44);
        expect_stats("flush", 16'd12, 16'd6);
        stat_clear = 1'b1;
        upd(32'h40, 1'b1, 32'h80, 1'b0);
        stat_clear = 1'b0;
        #1;
        expect_stats("clear", 16'd0, 16'd0);

        // Asynchronous reset between edges.
        upd(32'h40, 1'b1, 32'h80, 1'b0);
        expect_pred("pre_reset", 1'b1, 1'b1, 32'h80);
        expect_stats("pre_reset", 16'd1, 16'd1);
        #2;
        reset = 1'b1;
        #1;
        expect_pred("async_reset", 1'b0, 1'b0, 32'h44);
        expect_stats("async_reset", 16'd0, 16'd0);
        step();
        reset = 1'b0;

        // 4-bit statistics saturate at 15.
        upd_taken = 1'b1; upd_pred_taken = 1'b0; upd_pc = 32'h80; upd_target = 32'h0;
        s_upd_valid = 1'b1;
        for (int i = 0; i < 15; i++) step();
        check("sat_at_15", 32'(s_branches), 32'd15);
        for (int i = 0; i < 5; i++) step();
        s_upd_valid = 1'b0;
        #1;
        check("sat_branches", 32'(s_branches), 32'd15);
        check("sat_mispred", 32'(s_mispred), 32'd15);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
